sw_rx_fanout: RTL and testbench
===============================

Name: sw_rx_fanout

Overview:
Parametrised GMII receive fan-out for the switch model. It replicates one 125 MHz GMII receive stream onto PORT_NUM egress ports. Each port is enabled only at frame boundaries, in broadcast or unicast mode, so no port ever sees a truncated or mid-frame-started packet. It sits between the GMII receive interface and the per-port switch ingress logic, and includes optional per-port frame statistics.

Parameters:
PORT_NUM, 4, number of egress ports (1..16)
DATA_W, 8, GMII data width
PIPE_STAGES, 1, output register stages (1..4); sets the latency
CNT_W, 16, width of the per-port statistics counters

Ports:
I_125m_clk  in  1  sole clock, 125 MHz
I_rst_n  in  1  reset; synchronous, active-low
I_rx_gmii_dv  in  1  GMII receive data valid
I_rx_gmii_err  in  1  GMII receive error
I_rx_gmii_d  in  DATA_W  GMII receive data
I_mode  in  1  0 = broadcast to enabled ports; 1 = unicast to I_port_sel
I_port_sel  in  4  unicast target port index
I_port_en  in  PORT_NUM  per-port enable mask
I_cnt_clr  in  1  synchronous clear of all statistics counters
O_rx_gmii_dv  out  PORT_NUM  per-port data valid
O_rx_gmii_err  out  PORT_NUM  per-port error
O_rx_gmii_d  out  PORT_NUM*DATA_W  per-port data; port i occupies bits [i*DATA_W +: DATA_W]
O_frm_cnt  out  PORT_NUM*CNT_W  per-port count of forwarded frames
O_err_frm_cnt  out  PORT_NUM*CNT_W  per-port count of forwarded frames containing err

Behaviour:
- Reset: all registers clear on the clock edge while I_rst_n=0. At reset, all outputs and counters are 0, all ports are in IDLE, and dv_d=1.
- Frame start: start = I_rx_gmii_dv & ~dv_d, where dv_d is I_rx_gmii_dv registered by one cycle.
- Effective enable per port i: eff_en[i] = I_port_en[i] & (I_mode==0 | I_port_sel==i).
  - eff_en is sampled only in the start cycle.
  - An I_port_sel value >= PORT_NUM selects no port.
- Per-port state machine, with states IDLE, PASS, DROP:
  - IDLE, dv=0: stay in IDLE.
  - IDLE, dv=1, start & eff_en[i]: go to PASS.
  - IDLE, dv=1, otherwise (disabled port, or dv already high with no start seen): go to DROP.
  - PASS or DROP, dv=1: stay in the current state.
  - PASS or DROP, dv=0: go to IDLE.
- Gating decision (combinational on the current cycle):
  - The start cycle itself is forwarded when eff_en is set.
  - PASS with dv=1: forward dv, err and d unchanged.
  - Any other cycle (IDLE with dv=0, or DROP): drive dv=0, err=0, d=0.
  - err with dv=0 (carrier extension or false carrier) is never forwarded.
- Changes to I_port_en, I_mode or I_port_sel during a frame take effect at the next start. A frame in progress is neither cut off nor joined.
- Latency is exactly PIPE_STAGES cycles from the input to all output ports, with identical alignment across ports.
- Back-to-back frames: a single dv=0 cycle between frames is sufficient for the next start to be detected.
- Reset mid-frame:
  - Outputs go to 0 on the reset cycle, and the pipeline is flushed.
  - Because dv_d resets to 1, a frame still active when reset is released is dropped on every port.
  - Normal forwarding resumes at the next start.

Optional Feature:
Macro SW_RX_FANOUT_STAT_EN.
- Defined:
  - O_frm_cnt[i] increments by 1 on each PASS->IDLE transition.
  - O_err_frm_cnt[i] also increments on that transition if any forwarded cycle of the frame had err=1.
  - Counters wrap modulo 2^CNT_W.
  - I_cnt_clr=1 zeroes all counters and takes priority over a same-cycle increment.
  - Counter outputs are registered and change in the cycle after the frame end.
- Undefined: no counter logic is built, O_frm_cnt and O_err_frm_cnt are tied to 0, and I_cnt_clr is ignored.

Test Plan:
1. Broadcast, I_port_en=4'b1111, PIPE_STAGES=1, 64-byte frame with d=0x55 preamble then payload 0x00..0x3F: all 4 ports output the identical frame 1 cycle later; O_frm_cnt=1 on each port.
2. Unicast, I_mode=1, I_port_sel=2, two frames: only port 2 dv toggles; ports 0/1/3 hold dv=0, d=0x00; port 2 frame count=2.
3. I_port_en changes 4'b0001->4'b0011 at byte 10 of a 60-byte frame: port 1 stays silent for the whole frame and forwards the following frame complete.
4. Frame with err=1 on byte 20, then an IPG with dv=0, err=1, d=0x0F (carrier extension): the err byte is forwarded and O_err_frm_cnt=1; the extension cycles show err=0 on all outputs.
5. Reset asserted at byte 30 of a frame and released at byte 35: outputs are 0 from the reset edge; the rest of that frame is dropped; the next frame (1-cycle IPG) is forwarded intact.
6. Counter wrap with CNT_W=4: 17 frames give O_frm_cnt=1; I_cnt_clr pulsed in the frame-end cycle gives 0.

Source files
------------

// File: rtl/sw_rx_fanout.sv
`default_nettype none
// ============================================================================
// Module   : sw_rx_fanout
// Function : GMII rx fan-out to PORT_NUM ports, gated only at frame boundaries.
//            Define SW_RX_FANOUT_STAT_EN to build per-port frame counters.
// Revision : 1.0  initial release
// ============================================================================
module sw_rx_fanout #(
    parameter int PORT_NUM    = 4,
    parameter int DATA_W      = 8,
    parameter int PIPE_STAGES = 1,
    parameter int CNT_W       = 16
) (
    input  logic                         I_125m_clk,
    input  logic                         I_rst_n,
    input  logic                         I_rx_gmii_dv,
    input  logic                         I_rx_gmii_err,
    input  logic [DATA_W-1:0]            I_rx_gmii_d,
    input  logic                         I_mode,
    input  logic [3:0]                   I_port_sel,
    input  logic [PORT_NUM-1:0]          I_port_en,
    input  logic                         I_cnt_clr,
    output logic [PORT_NUM-1:0]          O_rx_gmii_dv,
    output logic [PORT_NUM-1:0]          O_rx_gmii_err,
    output logic [PORT_NUM*DATA_W-1:0]   O_rx_gmii_d,
    output logic [PORT_NUM*CNT_W-1:0]    O_frm_cnt,
    output logic [PORT_NUM*CNT_W-1:0]    O_err_frm_cnt
);

    localparam int c_GATE_W = PORT_NUM * (DATA_W + 2);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } state_t;

    logic                       r_dv_d;
    logic                       w_start;
    logic [PORT_NUM-1:0]        w_eff_en;
    logic [PORT_NUM-1:0]        w_fwd;
    logic [PORT_NUM-1:0]        w_gate_dv;
    logic [PORT_NUM-1:0]        w_gate_err;
    logic [PORT_NUM*DATA_W-1:0] w_gate_d;
    logic [c_GATE_W-1:0]        r_pipe [PIPE_STAGES];

    // dv_d resets high so a frame still active at reset release is never joined
    always_ff @(posedge I_125m_clk) begin
        if (!I_rst_n) r_dv_d <= 1'b1;
        else          r_dv_d <= I_rx_gmii_dv;
    end

    assign w_start = I_rx_gmii_dv & ~r_dv_d;

    generate
        for (genvar i = 0; i < PORT_NUM; i++) begin : g_port
            state_t r_state;

            assign w_eff_en[i]  = I_port_en[i] & (~I_mode | (I_port_sel == 4'(i)));
            assign w_fwd[i]     = I_rx_gmii_dv & ((r_state == ST_PASS) |
                                  ((r_state == ST_IDLE) & w_start & w_eff_en[i]));
            assign w_gate_dv[i]  = w_fwd[i];
            assign w_gate_err[i] = w_fwd[i] & I_rx_gmii_err;
            assign w_gate_d[i*DATA_W +: DATA_W] = w_fwd[i] ? I_rx_gmii_d : '0;

            always_ff @(posedge I_125m_clk) begin
                if (!I_rst_n)                r_state <= ST_IDLE;
                else if (!I_rx_gmii_dv)      r_state <= ST_IDLE;
                else if (r_state == ST_IDLE) r_state <= (w_start && w_eff_en[i]) ? ST_PASS : ST_DROP;
            end

`ifdef SW_RX_FANOUT_STAT_EN
            logic             r_err_seen;
            logic [CNT_W-1:0] r_frm_cnt;
            logic [CNT_W-1:0] r_err_cnt;
            logic             w_frm_end;

            assign w_frm_end = (r_state == ST_PASS) & ~I_rx_gmii_dv;

            always_ff @(posedge I_125m_clk) begin
                if (!I_rst_n) begin
                    r_err_seen <= 1'b0;
                    r_frm_cnt  <= '0;
                    r_err_cnt  <= '0;
                end else begin
                    // sticky across the forwarded cycles, cleared once forwarding stops
                    r_err_seen <= w_fwd[i] & (r_err_seen | I_rx_gmii_err);
                    if (I_cnt_clr) begin
                        r_frm_cnt <= '0;
                        r_err_cnt <= '0;
                    end else if (w_frm_end) begin
                        r_frm_cnt <= r_frm_cnt + 1'b1;
                        if (r_err_seen) r_err_cnt <= r_err_cnt + 1'b1;
                    end
                end
            end

            assign O_frm_cnt[i*CNT_W +: CNT_W]     = r_frm_cnt;
            assign O_err_frm_cnt[i*CNT_W +: CNT_W] = r_err_cnt;
`endif
        end
    endgenerate

`ifndef SW_RX_FANOUT_STAT_EN
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = I_cnt_clr;
    assign O_frm_cnt        = '0;
    assign O_err_frm_cnt    = '0;
`endif

    always_ff @(posedge I_125m_clk) begin
        if (!I_rst_n) begin
            for (int s = 0; s < PIPE_STAGES; s++) r_pipe[s] <= '0;
        end else begin
            r_pipe[0] <= {w_gate_dv, w_gate_err, w_gate_d};
            for (int s = 1; s < PIPE_STAGES; s++) r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign {O_rx_gmii_dv, O_rx_gmii_err, O_rx_gmii_d} = r_pipe[PIPE_STAGES-1];

endmodule
`default_nettype wire

// File: tb/tb_sw_rx_fanout.sv
`default_nettype none
// ============================================================================
// Module   : tb_sw_rx_fanout
// Function : directed bench for sw_rx_fanout (latency 1 and latency 3 copies).
// Revision : 1.0  initial release
// ============================================================================
module tb_sw_rx_fanout;

    localparam int PN   = 4;
    localparam int DW   = 8;
    localparam int CW   = 4;
    localparam int NONE = 9999;
`ifdef SW_RX_FANOUT_STAT_EN
    localparam bit STAT = 1'b1;
`else
    localparam bit STAT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n;
    logic           dv, err;
    logic [DW-1:0]  d;
    logic           mode;
    logic [3:0]     sel;
    logic [PN-1:0]  en;
    logic           cnt_clr;

    logic [PN-1:0]    o1_dv, o1_err, o3_dv, o3_err;
    logic [PN*DW-1:0] o1_d, o3_d;
    logic [PN*CW-1:0] o1_frm, o1_errf, o3_frm, o3_errf;

    always #4 clk = ~clk;

    sw_rx_fanout #(.PORT_NUM(PN), .DATA_W(DW), .PIPE_STAGES(1), .CNT_W(CW)) u_dut1 (
        .I_125m_clk(clk), .I_rst_n(rst_n), .I_rx_gmii_dv(dv), .I_rx_gmii_err(err),
        .I_rx_gmii_d(d), .I_mode(mode), .I_port_sel(sel), .I_port_en(en),
        .I_cnt_clr(cnt_clr), .O_rx_gmii_dv(o1_dv), .O_rx_gmii_err(o1_err),
        .O_rx_gmii_d(o1_d), .O_frm_cnt(o1_frm), .O_err_frm_cnt(o1_errf));

    sw_rx_fanout #(.PORT_NUM(PN), .DATA_W(DW), .PIPE_STAGES(3), .CNT_W(CW)) u_dut3 (
        .I_125m_clk(clk), .I_rst_n(rst_n), .I_rx_gmii_dv(dv), .I_rx_gmii_err(err),
        .I_rx_gmii_d(d), .I_mode(mode), .I_port_sel(sel), .I_port_en(en),
        .I_cnt_clr(cnt_clr), .O_rx_gmii_dv(o3_dv), .O_rx_gmii_err(o3_err),
        .O_rx_gmii_d(o3_d), .O_frm_cnt(o3_frm), .O_err_frm_cnt(o3_errf));

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int frm  [PN];
    int errf [PN];
    logic [39:0] hist [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic check_cnt(input string tag);
        logic [PN*CW-1:0] ef, ee;
        for (int i = 0; i < PN; i++) begin
            ef[i*CW +: CW] = STAT ? CW'(frm[i])  : '0;
            ee[i*CW +: CW] = STAT ? CW'(errf[i]) : '0;
        end
        check({tag, "_frm"}, 64'(o1_frm), 64'(ef));
        check({tag, "_errf"}, 64'(o1_errf), 64'(ee));
    endtask

    // One input cycle; mask says which ports must carry this cycle.
    task automatic step(input logic i_dv, input logic i_err, input logic [DW-1:0] i_d,
                        input logic [PN-1:0] mask, input bit in_rst);
        logic [PN-1:0]    edv, eer;
        logic [PN*DW-1:0] ed;
        edv = '0; eer = '0; ed = '0;
        rst_n = ~in_rst; dv = i_dv; err = i_err; d = i_d;
        for (int i = 0; i < PN; i++)
            if (!in_rst && i_dv && mask[i]) begin
                edv[i] = 1'b1;
                eer[i] = i_err;
                ed[i*DW +: DW] = i_d;
            end
        @(posedge clk);
        #1;
        cyc++;
        if (in_rst) begin
            hist[0] = '0; hist[1] = '0; hist[2] = '0;
        end else begin
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = {edv, eer, ed};
        end
        check($sformatf("lat1@%0d", cyc), 64'({o1_dv, o1_err, o1_d}), 64'(hist[0]));
        check($sformatf("lat3@%0d", cyc), 64'({o3_dv, o3_err, o3_d}), 64'(hist[2]));
    endtask

    // Frame of len bytes (pre x 0x55 then 0x00,0x01,...) followed by one idle cycle.
    task automatic send_frame(input int len, input logic [PN-1:0] mask, input int pre,
                              input int err_idx, input int chg_idx, input logic [PN-1:0] chg_en,
                              input int rst_from, input int rst_to, input bit clr);
        bit hit_rst;
        hit_rst = 1'b0;
        for (int k = 0; k < len; k++) begin
            if (k == chg_idx) en = chg_en;
            if (k >= rst_from && k < rst_to) hit_rst = 1'b1;
            step(1'b1, k == err_idx, (k < pre) ? 8'h55 : DW'(k - pre),
                 (k >= rst_from) ? '0 : mask, k >= rst_from && k < rst_to);
        end
        cnt_clr = clr;
        step(1'b0, 1'b0, '0, mask, 1'b0);
        cnt_clr = 1'b0;
        for (int i = 0; i < PN; i++) begin
            if (hit_rst || clr) begin
                frm[i] = 0; errf[i] = 0;
            end else if (mask[i]) begin
                frm[i]++;
                if (err_idx < len) errf[i]++;
            end
        end
        check_cnt("cnt");
    endtask

    initial begin
        for (int i = 0; i < PN; i++) begin frm[i] = 0; errf[i] = 0; end
        hist[0] = '0; hist[1] = '0; hist[2] = '0;
        mode = 1'b0; sel = 4'd0; en = '0; cnt_clr = 1'b0;

        // reset state
        repeat (3) step(1'b0, 1'b0, '0, '0, 1'b1);
        check_cnt("rst");
        repeat (2) step(1'b0, 1'b0, '0, '0, 1'b0);

        // broadcast, preamble + 64 payload bytes
        en = 4'b1111;
        send_frame(72, 4'b1111, 8, NONE, NONE, '0, NONE, NONE, 1'b0);

        // unicast to port 2, twice; then out-of-range selectors
        mode = 1'b1; sel = 4'd2;
        send_frame(20, 4'b0100, 0, NONE, NONE, '0, NONE, NONE, 1'b0);
        send_frame(20, 4'b0100, 0, NONE, NONE, '0, NONE, NONE, 1'b0);
        sel = 4'd5;
        send_frame(10, 4'b0000, 0, NONE, NONE, '0, NONE, NONE, 1'b0);
        sel = 4'd15;
        send_frame(10, 4'b0000, 0, NONE, NONE, '0, NONE, NONE, 1'b0);

        // enable change mid-frame: port 1 joins only at the next frame
        mode = 1'b0; en = 4'b0001;
        send_frame(60, 4'b0001, 0, NONE, 10, 4'b0011, NONE, NONE, 1'b0);
        send_frame(60, 4'b0011, 0, NONE, NONE, '0, NONE, NONE, 1'b0);
        // disable mid-frame: frame is not cut off
        en = 4'b1111;
        send_frame(12, 4'b1111, 0, NONE, 5, 4'b0000, NONE, NONE, 1'b0);
        en = 4'b1111;

        // err byte forwarded, then carrier extension never forwarded
        send_frame(30, 4'b1111, 0, 20, NONE, '0, NONE, NONE, 1'b0);
        repeat (3) step(1'b0, 1'b1, 8'h0F, 4'b1111, 1'b0);
        check_cnt("ext");

        // reset mid-frame; following frame after a 1-cycle gap is intact
        send_frame(50, 4'b1111, 0, NONE, NONE, '0, 30, 35, 1'b0);
        send_frame(20, 4'b1111, 0, NONE, NONE, '0, NONE, NONE, 1'b0);

        // counter wrap and clear priority
        cnt_clr = 1'b1;
        step(1'b0, 1'b0, '0, '0, 1'b0);
        cnt_clr = 1'b0;
        for (int i = 0; i < PN; i++) begin frm[i] = 0; errf[i] = 0; end
        check_cnt("clr");
        for (int f = 0; f < 17; f++)
            send_frame(4, 4'b1111, 0, (f == 16) ? 1 : NONE, NONE, '0, NONE, NONE, 1'b0);
        check_cnt("wrap");
        send_frame(4, 4'b1111, 0, NONE, NONE, '0, NONE, NONE, 1'b1);

        repeat (4) step(1'b0, 1'b0, '0, '0, 1'b0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
